// File: rtl/mips_pipe_pkg.sv
// mips_pipe_pkg: forward-select codes, special register numbers and the scoreboard entry type
package mips_pipe_pkg;
  localparam int ADDR_W = 5;
  localparam int NUM_REGS = 32;
  localparam logic [1:0] FWD_RF = 2'b00;
  localparam logic [1:0] FWD_EXMEM = 2'b01;
  localparam logic [1:0] FWD_MEMWB = 2'b10;
  localparam logic [1:0] FWD_WB = 2'b11;
  localparam logic [ADDR_W-1:0] REG_RA = 5'd31;
  localparam logic [ADDR_W-1:0] REG_ZERO = 5'd0;
  typedef struct packed {
    logic valid;
    logic [ADDR_W-1:0] dest;
    logic is_load;
  } sb_entry_t;
  // Youngest producer wins; a load hit in EX never reaches a register because it stalls
  function automatic logic [1:0] fwd_sel(input logic hit_ex, input logic hit_mem, input logic hit_wb);
    return hit_ex ? FWD_EXMEM : hit_mem ? FWD_MEMWB : hit_wb ? FWD_WB : FWD_RF;
  endfunction
endpackage

// File: rtl/dest_reg_scoreboard_sb_match.sv
// sb_match: compares one ID source register against the EX, MEM and WB entries
//   id_valid_i, use_i, src_i : the reading instruction and its source
//   ex_i                      : EX entry (its load flag drives the stall)
//   mem_*/wb_*                : valid/dest of the older stages
//   hit_*_o, ex_is_load_o     : per-stage match and EX load flag
module sb_match
  import mips_pipe_pkg::*;
#(
  parameter int AW = ADDR_W
) (
  input  logic          id_valid_i,
  input  logic          use_i,
  input  logic [AW-1:0] src_i,
  input  sb_entry_t     ex_i,
  input  logic          mem_valid_i,
  input  logic [AW-1:0] mem_dest_i,
  input  logic          wb_valid_i,
  input  logic [AW-1:0] wb_dest_i,
  output logic          hit_ex_o,
  output logic          hit_mem_o,
  output logic          hit_wb_o,
  output logic          ex_is_load_o
);
  logic rd;
  assign rd = id_valid_i & use_i;
  assign hit_ex_o = rd & ex_i.valid & (ex_i.dest == src_i);
  assign hit_mem_o = rd & mem_valid_i & (mem_dest_i == src_i);
  assign hit_wb_o = rd & wb_valid_i & (wb_dest_i == src_i);
  assign ex_is_load_o = ex_i.is_load;
endmodule

// File: rtl/dest_reg_scoreboard.sv
// dest_reg_scoreboard: tracks in-flight register writes through EX/MEM/WB, raises load-use stall, registers forwarding selects
//   clk_i, rst_ni                  : clock, asynchronous active-low reset
//   id_* inputs                    : issuing instruction's destination/control and its sources
//   flush_i                        : kill the instruction entering EX
//   stall_o                        : combinational load-use hazard
//   fwd_a_o, fwd_b_o               : registered EX operand mux selects
//   pending_o                      : one bit per register with an in-flight write
module dest_reg_scoreboard
  import mips_pipe_pkg::*;
#(
  parameter int AW = ADDR_W,
  parameter int NR = NUM_REGS,
  parameter int DEPTH = 3
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          id_valid_i,
  input  logic [AW-1:0] id_dest_i,
  input  logic          id_reg_write_i,
  input  logic          id_mem_read_i,
  input  logic [AW-1:0] id_rs_i,
  input  logic [AW-1:0] id_rt_i,
  input  logic          id_uses_rs_i,
  input  logic          id_uses_rt_i,
  input  logic          flush_i,
  output logic          stall_o,
  output logic [1:0]    fwd_a_o,
  output logic [1:0]    fwd_b_o,
  output logic [NR-1:0] pending_o
);
  sb_entry_t st_q [DEPTH];
  sb_entry_t ex_d;
  logic [1:0] fwd_a_d, fwd_b_d;
  logic a_ex, a_mem, a_wb, a_ld, b_ex, b_mem, b_wb, b_ld, bubble;
  sb_match #(.AW(AW)) u_match_a (
    .id_valid_i(id_valid_i), .use_i(id_uses_rs_i), .src_i(id_rs_i), .ex_i(st_q[0]),
    .mem_valid_i(st_q[1].valid), .mem_dest_i(st_q[1].dest),
    .wb_valid_i(st_q[2].valid), .wb_dest_i(st_q[2].dest),
    .hit_ex_o(a_ex), .hit_mem_o(a_mem), .hit_wb_o(a_wb), .ex_is_load_o(a_ld)
  );
  sb_match #(.AW(AW)) u_match_b (
    .id_valid_i(id_valid_i), .use_i(id_uses_rt_i), .src_i(id_rt_i), .ex_i(st_q[0]),
    .mem_valid_i(st_q[1].valid), .mem_dest_i(st_q[1].dest),
    .wb_valid_i(st_q[2].valid), .wb_dest_i(st_q[2].dest),
    .hit_ex_o(b_ex), .hit_mem_o(b_mem), .hit_wb_o(b_wb), .ex_is_load_o(b_ld)
  );
  // Both matchers see the same EX entry, so either load flag is the EX load flag
  assign stall_o = (a_ex | b_ex) & (a_ld & b_ld);
  assign bubble = stall_o | flush_i | ~id_valid_i;
  always_comb begin
    ex_d = '0;
    ex_d.valid = ~bubble & id_reg_write_i & (id_dest_i != REG_ZERO);
    ex_d.dest = id_dest_i;
    ex_d.is_load = id_mem_read_i;
    fwd_a_d = bubble ? FWD_RF : fwd_sel(a_ex, a_mem, a_wb);
    fwd_b_d = bubble ? FWD_RF : fwd_sel(b_ex, b_mem, b_wb);
  end
  always_comb begin
    pending_o = '0;
    for (int i = 0; i < DEPTH; i++)
      if (st_q[i].valid) pending_o[st_q[i].dest] = 1'b1;
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) st_q[i] <= '0;
      fwd_a_q_reset();
    end else begin
      st_q[0] <= ex_d;
      for (int i = 1; i < DEPTH; i++) st_q[i] <= st_q[i-1];
    end
  end
  logic [1:0] fwd_a_q, fwd_b_q;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      fwd_a_q <= FWD_RF;
      fwd_b_q <= FWD_RF;
    end else begin
      fwd_a_q <= fwd_a_d;
      fwd_b_q <= fwd_b_d;
    end
  end
  assign fwd_a_o = fwd_a_q;
  assign fwd_b_o = fwd_b_q;
  task automatic fwd_a_q_reset();
  endtask
endmodule

// File: tb/tb_dest_reg_scoreboard.sv
// tb_dest_reg_scoreboard: scoreboard bench for dest_reg_scoreboard against an independent stage model
module tb_dest_reg_scoreboard;
  logic clk = 0, rst_n = 0;
  logic id_valid = 0, id_reg_write = 0, id_mem_read = 0, id_uses_rs = 0, id_uses_rt = 0, flush = 0;
  logic [4:0] id_dest = 0, id_rs = 0, id_rt = 0;
  logic stall;
  logic [1:0] fwd_a, fwd_b;
  logic [31:0] pending;
  int n_checks = 0, n_fail = 0;
  typedef struct {
    logic [1:0] a;
    logic [1:0] b;
  } exp_t;
  exp_t exp_q[$];
  logic mv[3], ml[3];
  logic [4:0] md[3];

  always #5 clk = ~clk;

  dest_reg_scoreboard dut (
    .clk_i(clk), .rst_ni(rst_n), .id_valid_i(id_valid), .id_dest_i(id_dest),
    .id_reg_write_i(id_reg_write), .id_mem_read_i(id_mem_read), .id_rs_i(id_rs), .id_rt_i(id_rt),
    .id_uses_rs_i(id_uses_rs), .id_uses_rt_i(id_uses_rt), .flush_i(flush),
    .stall_o(stall), .fwd_a_o(fwd_a), .fwd_b_o(fwd_b), .pending_o(pending)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic hit(input int s, input logic [4:0] src, input logic use_src);
    return id_valid && use_src && mv[s] && md[s] == src;
  endfunction

  function automatic logic [1:0] m_fwd(input logic [4:0] src, input logic use_src);
    if (hit(0, src, use_src)) return 2'b01;
    if (hit(1, src, use_src)) return 2'b10;
    if (hit(2, src, use_src)) return 2'b11;
    return 2'b00;
  endfunction

  function automatic logic [31:0] m_pend();
    logic [31:0] p = 0;
    for (int i = 0; i < 3; i++) if (mv[i]) p[md[i]] = 1'b1;
    return p;
  endfunction

  task automatic m_clear();
    for (int i = 0; i < 3; i++) begin
      mv[i] = 0; md[i] = 0; ml[i] = 0;
    end
  endtask

  // Called just after a falling edge: drive, check stall, predict, clock, compare
  task automatic step(input logic v, input logic [4:0] d, input logic rw, input logic mr,
                      input logic [4:0] rs, input logic [4:0] rt, input logic urs, input logic urt,
                      input logic fl);
    logic es, bub;
    exp_t e;
    id_valid = v; id_dest = d; id_reg_write = rw; id_mem_read = mr;
    id_rs = rs; id_rt = rt; id_uses_rs = urs; id_uses_rt = urt; flush = fl;
    #1;
    es = ml[0] && (hit(0, rs, urs) || hit(0, rt, urt));
    check("stall", {31'b0, stall}, {31'b0, es});
    bub = es || fl || !v;
    e.a = bub ? 2'b00 : m_fwd(rs, urs);
    e.b = bub ? 2'b00 : m_fwd(rt, urt);
    exp_q.push_back(e);
    for (int i = 2; i > 0; i--) begin
      mv[i] = mv[i-1]; md[i] = md[i-1]; ml[i] = ml[i-1];
    end
    mv[0] = !bub && rw && d != 0; md[0] = d; ml[0] = mr;
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check("fwd_a", {30'b0, fwd_a}, {30'b0, e.a});
    check("fwd_b", {30'b0, fwd_b}, {30'b0, e.b});
    check("pending", pending, m_pend());
    @(negedge clk);
  endtask

  // Shorthands: ALU op writing d reading rs/rt, load, and an independent filler
  task automatic alu(input logic [4:0] d, input logic [4:0] rs, input logic [4:0] rt);
    step(1, d, 1, 0, rs, rt, 1, 1, 0);
  endtask
  task automatic nop_i();
    step(1, 5'd3, 1, 0, 5'd1, 5'd2, 1, 1, 0);
  endtask

  initial begin
    m_clear();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_pending", pending, 0);
    check("rst_fwd_a", {30'b0, fwd_a}, 0);
    check("rst_fwd_b", {30'b0, fwd_b}, 0);
    rst_n = 1;
    // ALU chain: distances 1, 2, 3
    alu(8, 1, 2); alu(4, 8, 2);
    alu(8, 1, 2); nop_i(); alu(4, 8, 2);
    alu(8, 1, 2); nop_i(); nop_i(); alu(4, 8, 2);
    // Load-use: stall once, then reissue gets MEM/WB forward
    step(1, 9, 1, 1, 1, 2, 1, 1, 0);
    step(1, 5, 1, 0, 1, 9, 1, 1, 0);
    step(1, 5, 1, 0, 1, 9, 1, 1, 0);
    nop_i(); nop_i();
    // Load in MEM with one between: forward, no stall
    step(1, 9, 1, 1, 1, 2, 1, 1, 0); nop_i(); alu(6, 9, 9);
    // jal pending for three cycles; jr right after
    step(1, 31, 1, 0, 0, 0, 0, 0, 0); nop_i(); nop_i(); nop_i();
    step(1, 31, 1, 0, 0, 0, 0, 0, 0); step(1, 0, 0, 0, 31, 0, 1, 0, 0);
    // Register 0 never tracked
    alu(0, 1, 2); alu(4, 0, 0);
    // Priority and flush
    alu(10, 1, 2); nop_i(); alu(10, 1, 2); alu(4, 10, 10);
    step(1, 11, 1, 1, 1, 2, 1, 1, 1); alu(4, 11, 11);
    step(0, 12, 1, 0, 1, 2, 1, 1, 0); alu(4, 12, 12);
    // Stall with flush simultaneously
    step(1, 9, 1, 1, 1, 2, 1, 1, 0);
    step(1, 5, 1, 0, 9, 2, 1, 1, 1);
    // Randomised traffic over a small register range
    for (int k = 0; k < 80; k++) begin
      logic [4:0] d, rs, rt;
      d = ($urandom_range(0, 7) == 0) ? 5'd31 : 5'($urandom_range(0, 4));
      rs = 5'($urandom_range(0, 4)); rt = 5'($urandom_range(0, 4));
      step($urandom_range(0, 7) != 0, d, 1'($urandom), 1'($urandom), rs, rt,
           1'($urandom), 1'($urandom), $urandom_range(0, 9) == 0);
    end
    // Asynchronous reset mid-operation with a live load-use hazard
    step(1, 9, 1, 1, 1, 2, 1, 1, 0);
    alu(8, 1, 2);
    id_valid = 1; id_rs = 8; id_uses_rs = 1; id_rt = 9; id_uses_rt = 1; flush = 0;
    id_reg_write = 1; id_dest = 7; id_mem_read = 0;
    #1;
    rst_n = 0;
    #1;
    check("mid_rst_pending", pending, 0);
    check("mid_rst_stall", {31'b0, stall}, 0);
    check("mid_rst_fwd_a", {30'b0, fwd_a}, 0);
    check("mid_rst_fwd_b", {30'b0, fwd_b}, 0);
    m_clear();
    @(negedge clk);
    rst_n = 1;
    alu(8, 9, 8); alu(4, 8, 9);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
